// File: rtl/nlp_btb_multi.sv
// Next-line predictor: fully-associative BTB predicting LANES slots of an aligned fetch group.
// Latency: lookup is combinational (zero cycles); updates, invalidations and occupancy land on the next edge.
// Backpressure: none; every request is accepted or resolved by fixed priority in the cycle it is presented.
//
// Ports:
//   clk, rst          clock, asynchronous active-low reset
//   lookup_pc         IF0 fetch PC; low log2(LANES)+2 bits ignored
//   pred_valid/taken  per-lane hit and counter MSB
//   pred_target/ctr   per-lane stored target and counter, lane 0 in the LSBs
//   upd_a_*           IF3 pre-decode training port (lower priority)
//   upd_b_*           backend resolve training port (higher priority)
//   inv_all           invalidate every entry and rewind the allocation head
//   inv_valid/inv_pc  invalidate the entry matching inv_pc
//   occupancy         registered count of valid entries
module nlp_btb_multi #(
   parameter int ENTRIES = 16,
   parameter int LANES   = 2,
   parameter int CTR_W   = 2,
   parameter int ADDR_W  = 32
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [ADDR_W-1:0]         lookup_pc,
   output logic [LANES-1:0]          pred_valid,
   output logic [LANES-1:0]          pred_taken,
   output logic [LANES*ADDR_W-1:0]   pred_target,
   output logic [LANES*CTR_W-1:0]    pred_ctr,
   input  logic                      upd_a_valid,
   input  logic [ADDR_W-1:0]         upd_a_pc,
   input  logic [ADDR_W-1:0]         upd_a_target,
   input  logic                      upd_a_taken,
   input  logic [CTR_W-1:0]          upd_a_ctr,
   input  logic                      upd_b_valid,
   input  logic [ADDR_W-1:0]         upd_b_pc,
   input  logic [ADDR_W-1:0]         upd_b_target,
   input  logic                      upd_b_taken,
   input  logic [CTR_W-1:0]          upd_b_ctr,
   input  logic                      inv_all,
   input  logic                      inv_valid,
   input  logic [ADDR_W-1:0]         inv_pc,
   output logic [$clog2(ENTRIES):0]  occupancy
);

   localparam int IDX_W = $clog2(ENTRIES);
   localparam int OCC_W = IDX_W + 1;
   localparam int LBITS = $clog2(LANES);
   localparam int TAG_W = ADDR_W - 2;

   localparam logic [CTR_W-1:0] CTR_MAX = {CTR_W{1'b1}};
   // Weakly-taken / weakly-not-taken seeds for fresh allocations.
   localparam logic [CTR_W-1:0] CTR_WT  = CTR_W'(1) << (CTR_W - 1);
   localparam logic [CTR_W-1:0] CTR_WNT = CTR_WT - CTR_W'(1);

   logic             entValid  [ENTRIES];
   logic [TAG_W-1:0] entPc     [ENTRIES];
   logic [ADDR_W-1:0] entTarget[ENTRIES];
   logic [CTR_W-1:0] entCtr    [ENTRIES];
   logic [IDX_W-1:0] head;
   logic [OCC_W-1:0] occ;

   // Returns {hit, index}; scanning downward leaves the lowest matching index.
   function automatic logic [IDX_W:0] findTag(input logic [TAG_W-1:0] tag);
      logic [IDX_W:0] r;
      r = '0;
      for (int e = ENTRIES - 1; e >= 0; e--) begin
         if (entValid[e] && (entPc[e] == tag)) r = {1'b1, IDX_W'(e)};
      end
      return r;
   endfunction

   function automatic logic [CTR_W-1:0] trainCtr(input logic [CTR_W-1:0] c, input logic taken);
      logic [CTR_W-1:0] r;
      if (taken) r = (c == CTR_MAX) ? c : c + CTR_W'(1);
      else       r = (c == '0)      ? c : c - CTR_W'(1);
      return r;
   endfunction

   // ---------------------------------------------------------------- lookup
   for (genvar gl = 0; gl < LANES; gl++) begin : gLane
      logic [TAG_W-1:0] laneTag;
      logic [IDX_W:0]   laneM;
      if (LBITS > 0) begin : gSel
         assign laneTag = {lookup_pc[ADDR_W-1:LBITS+2], LBITS'(gl)};
      end else begin : gOne
         assign laneTag = lookup_pc[ADDR_W-1:2];
      end
      assign laneM = findTag(laneTag);
      assign pred_valid[gl] = laneM[IDX_W];
      assign pred_target[gl*ADDR_W +: ADDR_W] = laneM[IDX_W] ? entTarget[laneM[IDX_W-1:0]] : '0;
      assign pred_ctr[gl*CTR_W +: CTR_W]      = laneM[IDX_W] ? entCtr[laneM[IDX_W-1:0]]    : '0;
      assign pred_taken[gl] = laneM[IDX_W] & entCtr[laneM[IDX_W-1:0]][CTR_W-1];
   end

   logic unusedBits;
   assign unusedBits = ^{lookup_pc[LBITS+1:0], upd_a_pc[1:0], upd_b_pc[1:0], inv_pc[1:0]};

   // ---------------------------------------------------------------- update resolution
   logic [TAG_W-1:0] aTag, bTag, invTag;
   logic [IDX_W:0]   aM, bM, iM;
   logic             invHit, aAct, bAct, aAlloc, bAlloc, aHitWr, bHitWr, invClr;
   logic [IDX_W-1:0] bAllocIdx, headNext;
   logic [OCC_W-1:0] occNext;
   logic [CTR_W-1:0] aHitCtr, bHitCtr, aNewCtr, bNewCtr;

   assign aTag   = upd_a_pc[ADDR_W-1:2];
   assign bTag   = upd_b_pc[ADDR_W-1:2];
   assign invTag = inv_pc[ADDR_W-1:2];
   assign aM     = findTag(aTag);
   assign bM     = findTag(bTag);
   assign iM     = findTag(invTag);

   always_comb begin
      invHit = inv_valid & iM[IDX_W];
      // B shadows A on the same PC; an invalidation swallows updates to the PC it kills.
      aAct = upd_a_valid & ~inv_all & ~(upd_b_valid & (aTag == bTag)) & ~(invHit & (aTag == invTag));
      bAct = upd_b_valid & ~inv_all & ~(invHit & (bTag == invTag));
      aAlloc = aAct & ~aM[IDX_W];
      bAlloc = bAct & ~bM[IDX_W];
      bAllocIdx = head + IDX_W'(aAlloc);
      // Allocation takes the slot even if the other port is training that slot's old occupant.
      aHitWr = aAct & aM[IDX_W] & ~(bAlloc & (bAllocIdx == aM[IDX_W-1:0]));
      bHitWr = bAct & bM[IDX_W] & ~(aAlloc & (head == bM[IDX_W-1:0]));
      // Invalidating a slot that is being reallocated this cycle is moot.
      invClr = invHit & ~inv_all
               & ~(aAlloc & (head == iM[IDX_W-1:0]))
               & ~(bAlloc & (bAllocIdx == iM[IDX_W-1:0]));
      headNext = inv_all ? '0 : head + IDX_W'(aAlloc) + IDX_W'(bAlloc);
      occNext  = inv_all ? '0 :
                 occ + OCC_W'(aAlloc & ~entValid[head])
                     + OCC_W'(bAlloc & ~entValid[bAllocIdx])
                     - OCC_W'(invClr);
      aHitCtr = trainCtr(upd_a_ctr, upd_a_taken);
      bHitCtr = trainCtr(upd_b_ctr, upd_b_taken);
      aNewCtr = upd_a_taken ? CTR_WT : CTR_WNT;
      bNewCtr = upd_b_taken ? CTR_WT : CTR_WNT;
   end

   // ---------------------------------------------------------------- state
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int e = 0; e < ENTRIES; e++) begin
            entValid[e]  <= 1'b0;
            entPc[e]     <= '0;
            entTarget[e] <= '0;
            entCtr[e]    <= '0;
         end
         head <= '0;
         occ  <= '0;
      end else begin
         if (inv_all) begin
            for (int e = 0; e < ENTRIES; e++) entValid[e] <= 1'b0;
         end else begin
            if (invClr) entValid[iM[IDX_W-1:0]] <= 1'b0;
            if (aHitWr) begin
               entTarget[aM[IDX_W-1:0]] <= upd_a_target;
               entCtr[aM[IDX_W-1:0]]    <= aHitCtr;
            end
            if (bHitWr) begin
               entTarget[bM[IDX_W-1:0]] <= upd_b_target;
               entCtr[bM[IDX_W-1:0]]    <= bHitCtr;
            end
            if (aAlloc) begin
               entValid[head]  <= 1'b1;
               entPc[head]     <= aTag;
               entTarget[head] <= upd_a_target;
               entCtr[head]    <= aNewCtr;
            end
            if (bAlloc) begin
               entValid[bAllocIdx]  <= 1'b1;
               entPc[bAllocIdx]     <= bTag;
               entTarget[bAllocIdx] <= upd_b_target;
               entCtr[bAllocIdx]    <= bNewCtr;
            end
         end
         head <= headNext;
         occ  <= occNext;
      end
   end

   assign occupancy = occ;

endmodule

// File: tb/tb_nlp_btb_multi.sv
// Directed bench for nlp_btb_multi (ENTRIES=16, LANES=2, CTR_W=2, ADDR_W=32).
// Inputs change 1 time unit after a rising edge; outputs are checked 1 unit later.
// Expected values are hand-computed constants.
module tb_nlp_btb_multi;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] lookup_pc;
   logic [1:0]  pred_valid, pred_taken;
   logic [63:0] pred_target;
   logic [3:0]  pred_ctr;
   logic        upd_a_valid, upd_a_taken, upd_b_valid, upd_b_taken;
   logic [31:0] upd_a_pc, upd_a_target, upd_b_pc, upd_b_target;
   logic [1:0]  upd_a_ctr, upd_b_ctr;
   logic        inv_all, inv_valid;
   logic [31:0] inv_pc;
   logic [4:0]  occupancy;

   int nChecks = 0;
   int nFails  = 0;

   nlp_btb_multi #(.ENTRIES(16), .LANES(2), .CTR_W(2), .ADDR_W(32)) dut (
      .clk(clk), .rst(rst), .lookup_pc(lookup_pc),
      .pred_valid(pred_valid), .pred_taken(pred_taken),
      .pred_target(pred_target), .pred_ctr(pred_ctr),
      .upd_a_valid(upd_a_valid), .upd_a_pc(upd_a_pc), .upd_a_target(upd_a_target),
      .upd_a_taken(upd_a_taken), .upd_a_ctr(upd_a_ctr),
      .upd_b_valid(upd_b_valid), .upd_b_pc(upd_b_pc), .upd_b_target(upd_b_target),
      .upd_b_taken(upd_b_taken), .upd_b_ctr(upd_b_ctr),
      .inv_all(inv_all), .inv_valid(inv_valid), .inv_pc(inv_pc),
      .occupancy(occupancy)
   );

   always #5 clk = ~clk;

   task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
      nChecks++;
      if (got !== exp) begin
         nFails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic clearReq();
      upd_a_valid = 0; upd_b_valid = 0; inv_all = 0; inv_valid = 0;
   endtask

   task automatic step();
      @(posedge clk); #1;
      clearReq();
   endtask

   task automatic setA(input logic [31:0] pc, input logic [31:0] tgt, input logic tk, input logic [1:0] c);
      upd_a_valid = 1; upd_a_pc = pc; upd_a_target = tgt; upd_a_taken = tk; upd_a_ctr = c;
   endtask

   task automatic setB(input logic [31:0] pc, input logic [31:0] tgt, input logic tk, input logic [1:0] c);
      upd_b_valid = 1; upd_b_pc = pc; upd_b_target = tgt; upd_b_taken = tk; upd_b_ctr = c;
   endtask

   task automatic look(input logic [31:0] pc);
      lookup_pc = pc; #1;
   endtask

   initial begin
      rst = 0; lookup_pc = 32'h1000; clearReq();
      upd_a_pc = 0; upd_a_target = 0; upd_a_taken = 0; upd_a_ctr = 0;
      upd_b_pc = 0; upd_b_target = 0; upd_b_taken = 0; upd_b_ctr = 0; inv_pc = 0;
      #12;
      rst = 1;
      @(posedge clk); #1;

      // Reset state
      look(32'h1000);
      checkVal("rst_valid", pred_valid, 2'b00);
      checkVal("rst_occ", occupancy, 0);
      checkVal("rst_target", pred_target, 0);

      // First allocation through port B
      setB(32'h1004, 32'h2000, 1, 1); step();
      look(32'h1000);
      checkVal("alloc_valid", pred_valid, 2'b10);
      checkVal("alloc_tgt1", pred_target[63:32], 32'h2000);
      checkVal("alloc_tgt0", pred_target[31:0], 0);
      checkVal("alloc_ctr1", pred_ctr[3:2], 2);
      checkVal("alloc_taken", pred_taken, 2'b10);
      checkVal("alloc_occ", occupancy, 1);

      // Hit training uses the incoming counter, saturating both ways
      setB(32'h1004, 32'h2000, 1, 3); step(); look(32'h1000);
      checkVal("sat_hi", pred_ctr[3:2], 3);
      setB(32'h1004, 32'h2000, 0, 0); step(); look(32'h1000);
      checkVal("sat_lo", pred_ctr[3:2], 0);
      checkVal("sat_lo_taken", pred_taken, 2'b00);
      setB(32'h1004, 32'h2100, 1, 1); step(); look(32'h1000);
      checkVal("train_ctr", pred_ctr[3:2], 2);
      checkVal("train_tgt", pred_target[63:32], 32'h2100);
      checkVal("train_occ", occupancy, 1);

      // Same PC on both ports: B only
      setA(32'h3000, 32'h3A00, 0, 0); setB(32'h3000, 32'h3B00, 0, 0); step();
      look(32'h3000);
      checkVal("same_valid", pred_valid, 2'b01);
      checkVal("same_tgt", pred_target[31:0], 32'h3B00);
      checkVal("same_ctr", pred_ctr[1:0], 1);
      checkVal("same_occ", occupancy, 2);

      // Both miss: two allocations
      setA(32'h4000, 32'h4400, 1, 0); setB(32'h5000, 32'h5500, 0, 0); step();
      look(32'h4000);
      checkVal("dual_a_tgt", pred_target[31:0], 32'h4400);
      checkVal("dual_a_ctr", pred_ctr[1:0], 2);
      look(32'h5000);
      checkVal("dual_b_tgt", pred_target[31:0], 32'h5500);
      checkVal("dual_b_ctr", pred_ctr[1:0], 1);
      look(32'h3000);
      checkVal("dual_keep", pred_target[31:0], 32'h3B00);
      checkVal("dual_occ", occupancy, 4);

      // Targeted invalidation drops the same-PC update; the other port still trains
      inv_valid = 1; inv_pc = 32'h1004;
      setB(32'h1004, 32'h2200, 1, 1);
      setA(32'h4000, 32'h4800, 0, 2);
      step();
      look(32'h1000);
      checkVal("inv_valid", pred_valid, 2'b00);
      checkVal("inv_occ", occupancy, 3);
      look(32'h4000);
      checkVal("inv_other_tgt", pred_target[31:0], 32'h4800);
      checkVal("inv_other_ctr", pred_ctr[1:0], 1);

      // Global invalidation beats everything
      inv_all = 1; inv_valid = 1; inv_pc = 32'h3000;
      setA(32'h9000, 32'h9900, 1, 1); setB(32'h5000, 32'h5A00, 1, 1);
      step();
      checkVal("invall_occ", occupancy, 0);
      look(32'h3000); checkVal("invall_3000", pred_valid, 0);
      look(32'h4000); checkVal("invall_4000", pred_valid, 0);
      look(32'h5000); checkVal("invall_5000", pred_valid, 0);
      look(32'h9000); checkVal("invall_9000", pred_valid, 0);

      // Fill all 16 entries from head 0
      for (int k = 0; k < 16; k++) begin
         setB(32'h6000 + 32'(k) * 32'h10, 32'h8000 + 32'(k), 1, 0);
         step();
      end
      checkVal("fill_occ", occupancy, 16);
      look(32'h6000); checkVal("fill_first", pred_target[31:0], 32'h8000);
      look(32'h60F0); checkVal("fill_last", pred_target[31:0], 32'h800F);

      // 17th allocation at index 0 wins over B training the old occupant there
      setA(32'h7000, 32'h7700, 1, 0); setB(32'h6000, 32'hBAD0, 1, 1); step();
      look(32'h6000); checkVal("wrap_evict", pred_valid, 2'b00);
      look(32'h7000);
      checkVal("wrap_tgt", pred_target[31:0], 32'h7700);
      checkVal("wrap_ctr", pred_ctr[1:0], 2);
      checkVal("wrap_occ", occupancy, 16);

      // Head is now 1: next allocation evicts the second fill PC only
      setB(32'h7100, 32'h7110, 0, 0); step();
      look(32'h6010); checkVal("head1_evict", pred_valid, 2'b00);
      look(32'h6020); checkVal("head1_keep", pred_valid, 2'b01);
      checkVal("head1_occ", occupancy, 16);

      // Asynchronous reset between edges with an update pending
      look(32'h7000);
      setB(32'hA000, 32'hAA00, 1, 1);
      #2; rst = 0; #1;
      checkVal("arst_valid", pred_valid, 0);
      checkVal("arst_occ", occupancy, 0);
      @(posedge clk); #1;
      clearReq();
      rst = 1;
      @(posedge clk); #1;
      look(32'hA000);
      checkVal("arst_nowrite", pred_valid, 0);
      checkVal("arst_occ2", occupancy, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end

endmodule
